cnn_fc_layer: RTL and testbench

- Sequential fully-connected layer: accepts the flattened pooled feature vector as a word stream and computes NUM_OUT dot products with stored weights plus bias, using one MAC per cycle.
- Emits one saturated fixed-point result per output neuron over a valid/ready handshake.
- Sits directly downstream of the 3D max-pool stage and produces the network's final outputs.

---
 rtl/cnn_fc_layer_if.sv | 34 +++
 rtl/cnn_fc_layer.sv | 168 ++++++++++++++++
 tb/tb_cnn_fc_layer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cnn_fc_layer_if.sv
// Stream and weight-bus bundle for cnn_fc_layer.
//   in_valid/in_data/in_ready     : feature-word input stream (valid/ready)
//   w_wr_en/w_addr/w_data         : weight/bias write port
//   out_valid/out_data/out_idx/out_ready : result stream (valid/ready)
// Modports: master = producer/consumer side, slave = the layer itself.
interface cnn_fc_layer_if #(
  parameter int NUM_IN     = 24,
  parameter int NUM_OUT    = 2,
  parameter int DATA_WIDTH = 16
);
  localparam int AW = $clog2(NUM_OUT * NUM_IN + NUM_OUT);
  localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  w_wr_en;
  logic [AW-1:0]         w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [OW-1:0]         out_idx;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, w_wr_en, w_addr, w_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_data, w_wr_en, w_addr, w_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/cnn_fc_layer.sv
// Sequential fully-connected layer: buffers NUM_IN signed Q-format feature
// words, then computes NUM_OUT dot products (one MAC per cycle) plus bias and
// emits one saturated result per neuron over a valid/ready handshake.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : begin inference (honoured only when idle)
//   busy     : high whenever not idle
//   done     : one-cycle pulse at end of inference
//   fc       : cnn_fc_layer_if.slave (input stream, weight bus, result stream)
// Build option: define FC_RELU_EN to clamp negative results to zero.
module cnn_fc_layer #(
  parameter int NUM_IN     = 24,
  parameter int NUM_OUT    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  cnn_fc_layer_if.slave fc
);
  localparam int NW   = NUM_OUT * NUM_IN;
  localparam int NMEM = NW + NUM_OUT;
  localparam int AW   = $clog2(NMEM);
  localparam int OW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int CW   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int PW   = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, EMIT, DONE} state_t;
  state_t state;

  // Weights at 0..NW-1 (o*NUM_IN+i), biases at NW..NW+NUM_OUT-1.
  logic [DATA_WIDTH-1:0] wmem [NMEM];
  logic [DATA_WIDTH-1:0] xbuf [NUM_IN];

  logic [CW-1:0]                cnt;
  logic [CW-1:0]                i;
  logic [OW-1:0]                o;
  logic                         acc_ld;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic [AW-1:0]                waddr_mac;
  logic [AW-1:0]                baddr;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  sum_next;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic [DATA_WIDTH-1:0]        bias_w;

  always_comb begin
    waddr_mac = AW'(o) * AW'(NUM_IN) + AW'(i);
    baddr     = AW'(NW) + AW'(o);
    prod      = $signed(xbuf[i]) * $signed(wmem[waddr_mac]);
    prod_ext  = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    sum_next  = acc + prod_ext;
    bias_w    = wmem[baddr];
    bias_ext  = $signed({{(ACC_WIDTH-DATA_WIDTH){bias_w[DATA_WIDTH-1]}}, bias_w}) <<< FRAC_BITS;
  end

  // Floor shift back to the Q format, then clamp to the signed output range.
  function automatic logic [DATA_WIDTH-1:0] sat_q(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0]       r;
    s = a >>> FRAC_BITS;
    if (!s[ACC_WIDTH-1] && (|s[ACC_WIDTH-2:DATA_WIDTH-1]))
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (s[ACC_WIDTH-1] && !(&s[ACC_WIDTH-2:DATA_WIDTH-1]))
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      r = s[DATA_WIDTH-1:0];
`ifdef FC_RELU_EN
    if (r[DATA_WIDTH-1])
      r = '0;
`else
`endif
    return r;
  endfunction

  // Buffers carry no reset so weights survive an aborted inference.
  always_ff @(posedge clk) begin
    if (fc.w_wr_en && (state == IDLE) && (fc.w_addr < AW'(NMEM)))
      wmem[fc.w_addr] <= fc.w_data;
    if ((state == LOAD) && fc.in_valid)
      xbuf[cnt] <= fc.in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      fc.in_ready  <= 1'b0;
      fc.out_valid <= 1'b0;
      fc.out_data  <= '0;
      fc.out_idx   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cnt          <= '0;
      i            <= '0;
      o            <= '0;
      acc_ld       <= 1'b0;
      acc          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            cnt         <= '0;
            fc.in_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          if (fc.in_valid) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(NUM_IN - 1)) begin
              state       <= MAC;
              fc.in_ready <= 1'b0;
              o           <= '0;
              i           <= '0;
              acc_ld      <= 1'b1;
            end
          end
        end
        MAC: begin
          // First MAC cycle of each neuron preloads the bias; the NUM_IN
          // accumulate cycles follow, the last one registering the result.
          if (acc_ld) begin
            acc    <= bias_ext;
            acc_ld <= 1'b0;
          end else begin
            acc <= sum_next;
            if (i == CW'(NUM_IN - 1)) begin
              i            <= '0;
              state        <= EMIT;
              fc.out_valid <= 1'b1;
              fc.out_data  <= sat_q(sum_next);
              fc.out_idx   <= o;
            end else begin
              i <= i + CW'(1);
            end
          end
        end
        EMIT: begin
          if (fc.out_ready) begin
            fc.out_valid <= 1'b0;
            if (o == OW'(NUM_OUT - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              o      <= o + OW'(1);
              acc_ld <= 1'b1;
              state  <= MAC;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_fc_layer.sv
module tb_cnn_fc_layer;
  localparam int NI   = 24;
  localparam int NO   = 2;
  localparam int DW   = 16;
  localparam int FB   = 8;
  localparam int NW   = NI * NO;
  localparam int NMEM = NW + NO;
  localparam int AW   = $clog2(NMEM);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  cnn_fc_layer_if #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_WIDTH(DW)) fc ();

  cnn_fc_layer #(
    .NUM_IN(NI), .NUM_OUT(NO), .DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(40)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .fc(fc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  int xv [NI];
  int wv [NO][NI];
  int bv [NO];

  typedef struct { int idx; int data; } exp_t;
  exp_t sbq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic int model(input int o);
    longint acc;
    acc = longint'(bv[o]) <<< FB;
    for (int k = 0; k < NI; k++) acc += longint'(xv[k]) * longint'(wv[o][k]);
    acc = acc >>> FB;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`ifdef FC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return int'(acc);
  endfunction

  // Scoreboard consumer: every cycle a result is presented it must match the
  // head of the queue; the head is retired on the handshake.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (reset_n && fc.out_valid === 1'b1) begin
      if (sbq.size() == 0) check("sb_unexpected", sbq.size(), 1);
      else begin
        check("out_idx", int'(fc.out_idx), sbq[0].idx);
        check("out_data", int'($signed(fc.out_data)), sbq[0].data);
        if (fc.out_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights();
    for (int a = 0; a < NMEM; a++) begin
      fc.w_wr_en = 1'b1;
      fc.w_addr  = AW'(a);
      fc.w_data  = (a < NW) ? DW'(wv[a / NI][a % NI]) : DW'(bv[a - NW]);
      tick();
    end
    fc.w_wr_en = 1'b0;
  endtask

  task automatic set_basic();
    for (int k = 0; k < NI; k++) begin
      xv[k] = 256; wv[0][k] = 256; wv[1][k] = -128;
    end
    bv[0] = 0; bv[1] = 256;
  endtask

  task automatic set_sat();
    for (int k = 0; k < NI; k++) begin
      xv[k] = 32767; wv[0][k] = 32767; wv[1][k] = -32768;
    end
    bv[0] = 0; bv[1] = 0;
  endtask

  task automatic set_rand();
    for (int k = 0; k < NI; k++) begin
      xv[k] = int'($urandom_range(0, 2047)) - 1024;
      for (int o = 0; o < NO; o++) wv[o][k] = int'($urandom_range(0, 4095)) - 2048;
    end
    for (int o = 0; o < NO; o++) bv[o] = int'($urandom_range(0, 8191)) - 4096;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, fc.in_ready, 0);
    check({tag, "_out_valid"}, fc.out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_out_data"}, int'(fc.out_data), 0);
    check({tag, "_out_idx"}, int'(fc.out_idx), 0);
  endtask

  task automatic run(input bit toggle, input int stall, input bit events, input int abort_at);
    int idx, last_hs, h, dc0;
    bit hs, phase;
    dc0 = done_cnt;
    fc.out_ready = (stall == 0);
    if (abort_at < 0)
      for (int o = 0; o < NO; o++) sbq.push_back('{idx: o, data: model(o)});
    start = 1'b1; tick(); start = 1'b0;
    check("busy_start", busy, 1);
    check("in_ready_load", fc.in_ready, 1);
    idx = 0; phase = 1'b0; last_hs = cyc; h = cyc;
    while (idx < NI && cyc - h < 200) begin
      fc.in_valid = toggle ? phase : 1'b1;
      phase = ~phase;
      fc.in_data = DW'(xv[idx]);
      if (events && idx == 5) begin
        fc.w_wr_en = 1'b1; fc.w_addr = '0; fc.w_data = 16'h7fff;
      end else fc.w_wr_en = 1'b0;
      hs = fc.in_valid && fc.in_ready;
      tick();
      if (hs) begin idx++; last_hs = cyc; end
    end
    fc.in_valid = 1'b0; fc.w_wr_en = 1'b0;
    check("load_words", idx, NI);
    check("in_ready_mac", fc.in_ready, 0);
    if (abort_at >= 0) begin
      repeat (abort_at) tick();
      reset_n = 1'b0; #1;
      check_reset_outputs("abort");
      check("abort_no_done", done_cnt - dc0, 0);
      repeat (2) tick();
      reset_n = 1'b1; tick();
      sbq.delete();
      return;
    end
    if (events) begin
      repeat (3) tick();
      start = 1'b1; tick(); start = 1'b0;
    end
    h = last_hs;
    for (int n = 0; n < NO; n++) begin
      while (fc.out_valid !== 1'b1 && cyc - h < 100) tick();
      check($sformatf("latency%0d", n), cyc - h, NI + 1);
      repeat (stall) tick();
      fc.out_ready = 1'b1; tick(); h = cyc;
      fc.out_ready = (stall == 0);
    end
    while (done !== 1'b1 && cyc - h < 10) tick();
    check("done_pulse", done, 1);
    tick();
    check("done_low", done, 0);
    check("busy_idle", busy, 0);
    check("done_count", done_cnt - dc0, 1);
    check("sb_drained", sbq.size(), 0);
    fc.out_ready = 1'b1;
  endtask

  initial begin
    fc.in_valid = 1'b0; fc.in_data = '0; fc.w_wr_en = 1'b0;
    fc.w_addr = '0; fc.w_data = '0; fc.out_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1; tick();

    set_basic(); load_weights();
    // Out-of-range address must not disturb anything.
    fc.w_wr_en = 1'b1; fc.w_addr = AW'(NMEM + 3); fc.w_data = 16'h1234; tick();
    fc.w_wr_en = 1'b0;
    run(1'b0, 0, 1'b0, -1);

    set_sat(); load_weights();
    run(1'b0, 0, 1'b0, -1);

    set_basic(); load_weights();
    run(1'b1, 5, 1'b0, -1);
    run(1'b0, 0, 1'b0, 11);
    run(1'b0, 0, 1'b0, -1);
    run(1'b0, 0, 1'b1, -1);

    for (int r = 0; r < 3; r++) begin
      set_rand(); load_weights();
      run(r[0], r, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
